// File: rtl/decode_stage.sv
// decode_stage: ID stage of a 5-stage MIPS-style pipeline.
//
// Holds the IF/ID register, the 32x32 register file (with write-through
// bypass from WB) and the ID/EX register. Detects load-use and
// branch-operand hazards, resolves beq/bne/j/jr in ID and flushes IF/ID
// on a taken control transfer.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   pc_in, instruction_in         fetch PC / word from IF
//   wb_en, wb_addr, wb_data       register-file write port from WB
//   ex_reg_write, ex_mem_read,
//   ex_rd                         destination info of the instruction in EX
//   mem_mem_read, mem_rd          destination info of the load in MEM
//   stall                         hold IF PC and IF/ID, bubble into ID/EX
//   branch_taken, branch_offset   taken beq/bne and its sign-extended imm16
//   jump_taken, new_addr          taken j/jr and its absolute target
//   id_pc .. valid                registered ID/EX outputs
//
// Flow control: stall is the only handshake. While stall=1 the IF/ID
// contents are held and ID/EX receives a bubble (valid=0). valid=1 on the
// ID/EX outputs marks a real instruction; a NOP (word 0) has valid=0.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic [31:0] instruction_in,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        mem_mem_read,
  input  logic [4:0]  mem_rd,
  output logic        stall,
  output logic        branch_taken,
  output logic [31:0] branch_offset,
  output logic        jump_taken,
  output logic [31:0] new_addr,
  output logic [31:0] id_pc,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] imm_ext,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  dest,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        valid
);

  // IF/ID register
  logic [31:0] ifid_pc_q, ifid_instr_q;

  // Register file
  logic [31:0] rf_q [32];

  // ID/EX register
  logic [31:0] id_pc_q, rs_data_q, rt_data_q, imm_ext_q;
  logic [4:0]  rs_q, rt_q, dest_q;
  logic [5:0]  opcode_q, funct_q;
  logic        reg_write_q, mem_read_q, mem_write_q, valid_q;

  // Decoded fields of the IF/ID word
  logic [5:0]  dec_op, dec_fn;
  logic [4:0]  dec_rs, dec_rt, dec_dest;
  logic [31:0] dec_imm, rs_val, rt_val, pc_plus4;
  logic        is_nop, is_rtype, is_jr, is_j, is_beq, is_bne, is_lw, is_sw, is_lui;
  logic        dec_reg_write, use_rs, use_rt, is_branch;
  logic        hz_load_use, hz_br_ex, hz_br_mem;

  assign dec_op   = ifid_instr_q[31:26];
  assign dec_fn   = ifid_instr_q[5:0];
  assign dec_rs   = ifid_instr_q[25:21];
  assign dec_rt   = ifid_instr_q[20:16];
  assign dec_imm  = {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]};
  assign pc_plus4 = ifid_pc_q + 32'd4;

  // The all-zero word is the NOP; it is excluded from the R-type class so
  // it carries no controls and no operand use.
  assign is_nop   = (ifid_instr_q == 32'h0);
  assign is_rtype = (dec_op == 6'h00) && !is_nop;
  assign is_jr    = is_rtype && (dec_fn == 6'h08);
  assign is_j     = (dec_op == 6'h02);
  assign is_beq   = (dec_op == 6'h04);
  assign is_bne   = (dec_op == 6'h05);
  assign is_lw    = (dec_op == 6'h23);
  assign is_sw    = (dec_op == 6'h2B);
  assign is_lui   = (dec_op == 6'h0F);

  assign dec_reg_write = (is_rtype && !is_jr) || is_lui || is_lw ||
                         (dec_op == 6'h08) || (dec_op == 6'h0C) ||
                         (dec_op == 6'h0D) || (dec_op == 6'h0A);
  assign dec_dest  = (dec_op == 6'h00) ? ifid_instr_q[15:11] : dec_rt;
  assign use_rs    = !(is_j || is_nop || is_lui);
  assign use_rt    = is_rtype || is_sw || is_beq || is_bne;
  assign is_branch = is_beq || is_bne || is_jr;

  // Register read with write-through from WB; r0 is hard zero.
  always_comb begin
    rs_val = rf_q[dec_rs];
    rt_val = rf_q[dec_rt];
    if (wb_en && (wb_addr == dec_rs)) rs_val = wb_data;
    if (wb_en && (wb_addr == dec_rt)) rt_val = wb_data;
    if (dec_rs == 5'd0) rs_val = 32'h0;
    if (dec_rt == 5'd0) rt_val = 32'h0;
  end

  // Branches compare in ID, so they must also wait for ALU results still
  // in EX and for loads still in MEM; other instructions only wait on a
  // load sitting in EX.
  assign hz_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                       ((use_rs && (ex_rd == dec_rs)) || (use_rt && (ex_rd == dec_rt)));
  assign hz_br_ex    = is_branch && ex_reg_write && (ex_rd != 5'd0) &&
                       ((use_rs && (ex_rd == dec_rs)) || (use_rt && (ex_rd == dec_rt)));
  assign hz_br_mem   = is_branch && mem_mem_read && (mem_rd != 5'd0) &&
                       ((use_rs && (mem_rd == dec_rs)) || (use_rt && (mem_rd == dec_rt)));

  assign stall         = hz_load_use || hz_br_ex || hz_br_mem;
  assign branch_taken  = !stall && ((is_beq && (rs_val == rt_val)) ||
                                    (is_bne && (rs_val != rt_val)));
  assign jump_taken    = !stall && (is_j || is_jr);
  assign branch_offset = dec_imm;

  always_comb begin
    new_addr = 32'h0;
    if (is_j)       new_addr = {pc_plus4[31:28], ifid_instr_q[25:0], 2'b00};
    else if (is_jr) new_addr = rs_val;
  end

  // IF/ID: a taken transfer replaces the wrong-path word with a NOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= 32'h0;
    end else if (branch_taken || jump_taken) begin
      ifid_pc_q    <= pc_in;
      ifid_instr_q <= 32'h0;
    end else if (!stall) begin
      ifid_pc_q    <= pc_in;
      ifid_instr_q <= instruction_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || stall) begin
      id_pc_q     <= 32'h0;
      rs_data_q   <= 32'h0;
      rt_data_q   <= 32'h0;
      imm_ext_q   <= 32'h0;
      rs_q        <= 5'd0;
      rt_q        <= 5'd0;
      dest_q      <= 5'd0;
      opcode_q    <= 6'd0;
      funct_q     <= 6'd0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      id_pc_q     <= ifid_pc_q;
      rs_data_q   <= rs_val;
      rt_data_q   <= rt_val;
      imm_ext_q   <= dec_imm;
      rs_q        <= dec_rs;
      rt_q        <= dec_rt;
      dest_q      <= dec_dest;
      opcode_q    <= dec_op;
      funct_q     <= dec_fn;
      reg_write_q <= dec_reg_write;
      mem_read_q  <= is_lw;
      mem_write_q <= is_sw;
      valid_q     <= !is_nop;
    end
  end

  assign id_pc     = id_pc_q;
  assign rs_data   = rs_data_q;
  assign rt_data   = rt_data_q;
  assign imm_ext   = imm_ext_q;
  assign rs        = rs_q;
  assign rt        = rt_q;
  assign dest      = dest_q;
  assign opcode    = opcode_q;
  assign funct     = funct_q;
  assign reg_write = reg_write_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: self-checking bench for decode_stage.
// ID/EX expectations are queued when an instruction sits in IF/ID and are
// popped and compared one clock edge later; combinational outputs are
// compared inline by each scenario task.
module tb_decode_stage;

  logic        clk, rst;
  logic [31:0] pc_in, instruction_in;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_reg_write, ex_mem_read;
  logic [4:0]  ex_rd;
  logic        mem_mem_read;
  logic [4:0]  mem_rd;
  logic        stall, branch_taken, jump_taken;
  logic [31:0] branch_offset, new_addr;
  logic [31:0] id_pc, rs_data, rt_data, imm_ext;
  logic [4:0]  rs, rt, dest;
  logic [5:0]  opcode, funct;
  logic        reg_write, mem_read, mem_write, valid;

  decode_stage dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instruction_in(instruction_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
    .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump_taken(jump_taken), .new_addr(new_addr),
    .id_pc(id_pc), .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext),
    .rs(rs), .rt(rt), .dest(dest), .opcode(opcode), .funct(funct),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .valid(valid)
  );

  // Hand-encoded instructions
  localparam logic [31:0] ADD_R3_R5_R0 = 32'h00A01820;
  localparam logic [31:0] ADD_R6_R0_R0 = 32'h00003020;
  localparam logic [31:0] ADD_R4_R2_R1 = 32'h00412020;
  localparam logic [31:0] ADD_R6_R5_R0 = 32'h00A03020;
  localparam logic [31:0] ADDI_R7_R1_5 = 32'h20270005;
  localparam logic [31:0] BEQ_R1_M1    = 32'h1021FFFF;
  localparam logic [31:0] BEQ_R1_2     = 32'h10210002;
  localparam logic [31:0] BNE_R1_4     = 32'h14210004;
  localparam logic [31:0] J_100        = 32'h08000100;
  localparam logic [31:0] JR_R5        = 32'h00A00008;
  localparam logic [31:0] LW_R8_4_R1   = 32'h8C280004;
  localparam logic [31:0] SW_R5_M8_R1  = 32'hAC25FFF8;
  localparam logic [31:0] LUI_R9_RS3   = 32'h3C691234;

  logic [158:0] exp_q[$];
  string        name_q[$];
  logic [158:0] idex_obs;
  int           n_cmp = 0;
  int           n_bad = 0;

  assign idex_obs = {id_pc, rs_data, rt_data, imm_ext, rs, rt, dest, opcode, funct,
                     reg_write, mem_read, mem_write, valid};

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] rsd,
                                      input logic [31:0] rtd, input logic [31:0] imm,
                                      input logic [4:0] rs_f, input logic [4:0] rt_f,
                                      input logic [4:0] dst, input logic [5:0] op,
                                      input logic [5:0] fn, input logic rw,
                                      input logic mr, input logic mw, input logic v);
    return {pc, rsd, rtd, imm, rs_f, rt_f, dst, op, fn, rw, mr, mw, v};
  endfunction

  task automatic push(input string nm, input logic [158:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // One clock edge; an expectation queued before the edge is what ID/EX
  // must show just after it.
  task automatic step();
    logic [158:0] e;
    string        nm;
    logic         have;
    e = '0;
    nm = "";
    @(posedge clk);
    have = (exp_q.size() > 0);
    if (have) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
    end
    #1;
    if (have) begin
      n_cmp++;
      if (idex_obs !== e) begin
        n_bad++;
        $display("FAIL %s: id_ex got %h expected %h", nm, idex_obs, e);
      end
    end
  endtask

  task automatic load(input logic [31:0] pc, input logic [31:0] ins);
    pc_in = pc;
    instruction_in = ins;
    step();
    instruction_in = 32'h0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    instruction_in = 32'h0;
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    step();
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pc_in = 32'h44; instruction_in = ADD_R4_R2_R1;
    ex_mem_read = 1'b1; ex_rd = 5'd2;
    step(); step();
    rst = 1'b0; instruction_in = 32'h0;
    #1;
    n_cmp++; if (idex_obs !== '0) begin n_bad++; $display("FAIL rst_idex: got %h expected 0", idex_obs); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b expected 0", stall); end
    n_cmp++; if (branch_taken !== 1'b0) begin n_bad++; $display("FAIL rst_bt: got %b expected 0", branch_taken); end
    n_cmp++; if (jump_taken !== 1'b0) begin n_bad++; $display("FAIL rst_jt: got %b expected 0", jump_taken); end
    n_cmp++; if (new_addr !== 32'h0) begin n_bad++; $display("FAIL rst_new_addr: got %h expected 0", new_addr); end
    n_cmp++; if (branch_offset !== 32'h0) begin n_bad++; $display("FAIL rst_offset: got %h expected 0", branch_offset); end
    ex_mem_read = 1'b0; ex_rd = 5'd0;
  endtask

  task automatic test_bypass();
    load(32'h100, ADD_R3_R5_R0);
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
    push("bypass_add", mk(32'h100, 32'h1234, 32'h0, 32'h1820, 5'd5, 5'd0, 5'd3, 6'h00, 6'h20, 1, 0, 0, 1));
    step();
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
  endtask

  task automatic test_r0();
    wb_write(5'd0, 32'hFFFFFFFF);
    load(32'h104, ADD_R6_R0_R0);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    ex_mem_read = 1'b1; ex_rd = 5'd0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL r0_no_stall: got %b expected 0", stall); end
    push("r0_read", mk(32'h104, 32'h0, 32'h0, 32'h3020, 5'd0, 5'd0, 5'd6, 6'h00, 6'h20, 1, 0, 0, 1));
    step();
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    ex_mem_read = 1'b0;
  endtask

  task automatic test_load_use();
    wb_write(5'd2, 32'h22);
    wb_write(5'd1, 32'h11);
    load(32'h200, ADD_R4_R2_R1);
    ex_mem_read = 1'b1; ex_rd = 5'd2;
    pc_in = 32'h204; instruction_in = ADDI_R7_R1_5;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall: got %b expected 1", stall); end
    push("lu_bubble", '0);
    step();
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_release: got %b expected 0", stall); end
    push("lu_add", mk(32'h200, 32'h22, 32'h11, 32'h2020, 5'd2, 5'd1, 5'd4, 6'h00, 6'h20, 1, 0, 0, 1));
    step();
    instruction_in = 32'h0;
    // addi does not read rt, and a MEM load only matters for branches
    ex_mem_read = 1'b1; ex_rd = 5'd7;
    mem_mem_read = 1'b1; mem_rd = 5'd1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL addi_no_stall: got %b expected 0", stall); end
    push("lu_addi", mk(32'h204, 32'h11, 32'h0, 32'h5, 5'd1, 5'd7, 5'd7, 6'h08, 6'h05, 1, 0, 0, 1));
    step();
    ex_mem_read = 1'b0; ex_rd = 5'd0; mem_mem_read = 1'b0; mem_rd = 5'd0;
  endtask

  task automatic test_branch();
    wb_write(5'd1, 32'h7);
    load(32'h300, BEQ_R1_M1);
    pc_in = 32'h304; instruction_in = ADD_R3_R5_R0;
    #1;
    n_cmp++; if (branch_taken !== 1'b1) begin n_bad++; $display("FAIL beq_taken: got %b expected 1", branch_taken); end
    n_cmp++; if (branch_offset !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL beq_offset: got %h expected ffffffff", branch_offset); end
    n_cmp++; if (jump_taken !== 1'b0) begin n_bad++; $display("FAIL beq_jt: got %b expected 0", jump_taken); end
    push("beq_idex", mk(32'h300, 32'h7, 32'h7, 32'hFFFFFFFF, 5'd1, 5'd1, 5'd1, 6'h04, 6'h3F, 0, 0, 0, 1));
    step();
    pc_in = 32'h310; instruction_in = BNE_R1_4;
    #1;
    n_cmp++; if (branch_offset !== 32'h0) begin n_bad++; $display("FAIL flush_offset: got %h expected 0", branch_offset); end
    step();
    instruction_in = 32'h0;
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b expected 0", valid); end
    n_cmp++; if (funct !== 6'h00) begin n_bad++; $display("FAIL flush_funct: got %h expected 00", funct); end
    #1;
    n_cmp++; if (branch_taken !== 1'b0) begin n_bad++; $display("FAIL bne_not_taken: got %b expected 0", branch_taken); end
    n_cmp++; if (branch_offset !== 32'h4) begin n_bad++; $display("FAIL bne_offset: got %h expected 4", branch_offset); end
    push("bne_idex", mk(32'h310, 32'h7, 32'h7, 32'h4, 5'd1, 5'd1, 5'd1, 6'h05, 6'h04, 0, 0, 0, 1));
    step();
  endtask

  task automatic test_branch_hazard();
    load(32'h400, BEQ_R1_2);
    ex_reg_write = 1'b1; ex_rd = 5'd1;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL bh_ex_stall: got %b expected 1", stall); end
    n_cmp++; if (branch_taken !== 1'b0) begin n_bad++; $display("FAIL bh_ex_bt: got %b expected 0", branch_taken); end
    push("bh_bubble_ex", '0);
    step();
    ex_reg_write = 1'b0; ex_rd = 5'd0;
    mem_mem_read = 1'b1; mem_rd = 5'd1;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL bh_mem_stall: got %b expected 1", stall); end
    push("bh_bubble_mem", '0);
    step();
    mem_mem_read = 1'b0; mem_rd = 5'd0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL bh_release: got %b expected 0", stall); end
    n_cmp++; if (branch_taken !== 1'b1) begin n_bad++; $display("FAIL bh_taken: got %b expected 1", branch_taken); end
    push("bh_beq", mk(32'h400, 32'h7, 32'h7, 32'h2, 5'd1, 5'd1, 5'd1, 6'h04, 6'h02, 0, 0, 0, 1));
    step();
  endtask

  task automatic test_jump();
    load(32'h00400000, J_100);
    #1;
    n_cmp++; if (jump_taken !== 1'b1) begin n_bad++; $display("FAIL j_taken: got %b expected 1", jump_taken); end
    n_cmp++; if (new_addr !== 32'h00000400) begin n_bad++; $display("FAIL j_target: got %h expected 00000400", new_addr); end
    n_cmp++; if (branch_taken !== 1'b0) begin n_bad++; $display("FAIL j_bt: got %b expected 0", branch_taken); end
    push("j_idex", mk(32'h00400000, 32'h0, 32'h0, 32'h100, 5'd0, 5'd0, 5'd0, 6'h02, 6'h00, 0, 0, 0, 1));
    step();
    load(32'h500, JR_R5);
    ex_reg_write = 1'b1; ex_rd = 5'd5;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL jr_stall: got %b expected 1", stall); end
    n_cmp++; if (jump_taken !== 1'b0) begin n_bad++; $display("FAIL jr_jt_stalled: got %b expected 0", jump_taken); end
    push("jr_bubble", '0);
    step();
    ex_reg_write = 1'b0; ex_rd = 5'd0;
    #1;
    n_cmp++; if (jump_taken !== 1'b1) begin n_bad++; $display("FAIL jr_taken: got %b expected 1", jump_taken); end
    n_cmp++; if (new_addr !== 32'h1234) begin n_bad++; $display("FAIL jr_target: got %h expected 00001234", new_addr); end
    push("jr_idex", mk(32'h500, 32'h1234, 32'h0, 32'h8, 5'd5, 5'd0, 5'd0, 6'h00, 6'h08, 0, 0, 0, 1));
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0]  ins [3];
    logic [158:0] ex  [3];
    ins[0] = LW_R8_4_R1; ins[1] = SW_R5_M8_R1; ins[2] = LUI_R9_RS3;
    ex[0] = mk(32'h600, 32'h7, 32'h0, 32'h4, 5'd1, 5'd8, 5'd8, 6'h23, 6'h04, 1, 1, 0, 1);
    ex[1] = mk(32'h604, 32'h7, 32'h1234, 32'hFFFFFFF8, 5'd1, 5'd5, 5'd5, 6'h2B, 6'h38, 0, 0, 1, 1);
    ex[2] = mk(32'h608, 32'h0, 32'h0, 32'h1234, 5'd3, 5'd9, 5'd9, 6'h0F, 6'h34, 1, 0, 0, 1);
    load(32'h600, ins[0]);
    for (int k = 0; k < 3; k++) begin
      pc_in = 32'h604 + 32'(4 * k);
      instruction_in = (k < 2) ? ins[k + 1] : 32'h0;
      // lui ignores its rs field, so a load into that register is harmless
      ex_mem_read = (k == 2); ex_rd = (k == 2) ? 5'd3 : 5'd0;
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_stall_%0d: got %b expected 0", k, stall); end
      push($sformatf("b2b_%0d", k), ex[k]);
      step();
    end
    ex_mem_read = 1'b0; ex_rd = 5'd0;
  endtask

  task automatic test_random_regs();
    logic [4:0]  a;
    logic [31:0] d, ins, pc;
    logic        byp;
    for (int i = 0; i < 8; i++) begin
      a   = 5'($urandom_range(1, 31));
      d   = $urandom;
      byp = 1'($urandom_range(0, 1));
      pc  = 32'h800 + 32'(4 * i);
      ins = {6'h00, a, 5'd0, 5'd10, 5'd0, 6'h20};
      if (!byp) wb_write(a, d);
      load(pc, ins);
      if (byp) begin wb_en = 1'b1; wb_addr = a; wb_data = d; end
      push($sformatf("rand_rd_%0d", i), mk(pc, d, 32'h0, 32'h5020, a, 5'd0, 5'd10, 6'h00, 6'h20, 1, 0, 0, 1));
      step();
      wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    end
  endtask

  task automatic test_reset_mid_stall();
    wb_write(5'd5, 32'h55);
    load(32'h700, ADD_R4_R2_R1);
    ex_mem_read = 1'b1; ex_rd = 5'd2;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rms_stall: got %b expected 1", stall); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rms_cleared: got %b expected 0", stall); end
    n_cmp++; if (idex_obs !== '0) begin n_bad++; $display("FAIL rms_idex: got %h expected 0", idex_obs); end
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    load(32'h704, ADD_R6_R5_R0);
    push("rms_regs_cleared", mk(32'h704, 32'h0, 32'h0, 32'h3020, 5'd5, 5'd0, 5'd6, 6'h00, 6'h20, 1, 0, 0, 1));
    step();
  endtask

  initial begin
    rst = 1'b1;
    pc_in = 32'h0; instruction_in = 32'h0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    mem_mem_read = 1'b0; mem_rd = 5'd0;
    test_reset();
    test_bypass();
    test_r0();
    test_load_use();
    test_branch();
    test_branch_hazard();
    test_jump();
    test_back_to_back();
    test_random_regs();
    test_reset_mid_stall();
    step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clk  in  1  rising-edge clock; rst  in  1  reset, synchronous, active-high.
REQ-002 pc_in  in  32  fetch PC from IF; instruction_in  in  32  fetched word.
REQ-003 wb_en  in  1, wb_addr  in  5, wb_data  in  32  register-file write port from WB.
REQ-004 ex_reg_write  in  1, ex_mem_read  in  1, ex_rd  in  5  destination info of the instruction in EX.
REQ-005 mem_mem_read  in  1, mem_rd  in  5  destination info of the load in MEM.
REQ-006 stall  out  1  hold IF PC and IF/ID; branch_taken  out  1; branch_offset  out  32  sign-extended imm16; jump_taken  out  1; new_addr  out  32.
REQ-007 ID/EX outputs (registered): id_pc 32, rs_data 32, rt_data 32, imm_ext 32, rs 5, rt 5, dest 5, opcode 6, funct 6, reg_write 1, mem_read 1, mem_write 1, valid 1.

Function
REQ-008 Internal IF/ID register (pc, instr) SHALL load pc_in/instruction_in on a clock edge when stall=0; it holds when stall=1.
REQ-009 When branch_taken or jump_taken is 1 at the clock edge, IF/ID SHALL load instr=0x00000000 (NOP) instead of instruction_in; this flush has priority over the load.
REQ-010 Register file: 32x32; r0 reads 0; write on the clock edge when wb_en=1 and wb_addr!=0.
REQ-011 A same-cycle read of wb_addr!=0 with wb_en=1 SHALL return wb_data (write-through bypass).
REQ-012 Decode: rs=instr[25:21], rt=instr[20:16], imm_ext=sign-extended instr[15:0].
REQ-013 For R-type (opcode 0), dest=instr[15:11]; otherwise dest=rt.
REQ-014 Control decode: R-type except jr, addi(08), andi(0C), ori(0D), lui(0F), slti(0A) -> reg_write=1; lw(23) -> reg_write=1, mem_read=1; sw(2B) -> mem_write=1; beq(04), bne(05), j(02), jr, NOP -> all controls 0.
REQ-015 Operand use: rs is used by all except j/NOP/lui; rt is used by R-type, sw, beq, bne.
REQ-016 Load-use hazard: stall=1 when ex_mem_read=1, ex_rd!=0 and ex_rd matches a used rs/rt.
REQ-017 Branch hazard: for beq/bne/jr, stall=1 also when ex_reg_write=1 and ex_rd!=0 matches a used operand.
REQ-018 Branch hazard: for beq/bne/jr, stall=1 also when mem_mem_read=1 and mem_rd!=0 matches a used operand.
REQ-019 stall, branch_taken, jump_taken, branch_offset and new_addr SHALL be combinational from IF/ID contents and inputs (same cycle).
REQ-020 branch_taken=1 iff stall=0 and either beq with rs_data==rt_data or bne with rs_data!=rt_data; branch_offset=imm_ext. IF adds branch_offset<<2 to its current PC (branch PC+4), giving target PC+4+4*imm.
REQ-021 jump_taken=1 iff stall=0 and the instruction is j or jr.
REQ-022 new_addr: for j, {id_pc+4[31:28], instr[25:0], 2'b00}; for jr, rs_data; otherwise 0.
REQ-023 ID/EX update every edge: if stall=1, load a bubble (all controls 0, valid=0, data 0); otherwise load the decoded values and valid=1, except valid=0 when instr==0.
REQ-024 Latency: an instruction in IF/ID appears on the ID/EX outputs after exactly one clock edge.
REQ-025 branch_taken and jump_taken SHALL never both be 1.

Reset
REQ-026 While rst=1 at an edge: IF/ID pc=0, instr=0; all ID/EX outputs 0; all 32 registers cleared to 0. rst has priority over stall and flush.
REQ-027 After reset, with IF/ID holding NOP: stall=0, branch_taken=0, jump_taken=0, new_addr=0, branch_offset=0.
REQ-028 Reset mid-stall SHALL clear the stall the next cycle; the stalled instruction is discarded.

Verification
REQ-029 wb writes r5=0x1234 while IF/ID decodes add r3,r5,r0 -> next cycle rs_data=0x1234, dest=3, reg_write=1.
REQ-030 lw r2 in EX (ex_mem_read=1, ex_rd=2) with add r4,r2,r1 in ID -> stall=1 for 1 cycle; ID/EX valid=0; add issues next cycle.
REQ-031 beq r1,r1,imm=0xFFFF with r1=7 -> branch_taken=1, branch_offset=0xFFFFFFFF; next IF/ID instr=0.
REQ-032 beq whose rs equals ex_rd with ex_reg_write=1 -> stall=1, branch_taken=0; resolves the following cycle.
REQ-033 j target=0x0000100 at id_pc=0x00400000 -> jump_taken=1, new_addr=0x00000400.
REQ-034 wb_en=1, wb_addr=0, wb_data=0xFFFFFFFF, then read r0 -> 0.
